seven_segment_capture: RTL and testbench
========================================

Name: seven_segment_capture

Overview:
- Inverse of the team's hex-to-seven-segment encoder.
- Samples a time-multiplexed, active-low seven-segment bus: one-hot digit select plus 7 segment lines.
- Qualifies each digit pattern for stability, decodes it back to a hex nibble, and assembles a multi-digit frame.
- Used for loopback checking of display drivers and for reading external seven-segment sources into the audio design.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 3, consecutive identical accepted samples required to qualify a digit (1..255).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- sample_en  input  1  bus sample strobe; segment/select lines are examined only when high.
- digit_sel  input  NUM_DIGITS  one-hot digit select; bit i = digit i.
- seven  input  7  active-low segments; bit0=a … bit6=g.
- error_clr  input  1  clears pattern_error.
- value  output  4*NUM_DIGITS  last complete frame; digit i in bits [4i+3:4i].
- blank_mask  output  NUM_DIGITS  bit i set if digit i was blank in the last frame.
- frame_valid  output  1  one-cycle pulse when value/blank_mask update.
- pattern_error  output  1  sticky; an undecodable pattern was qualified.

Behaviour:
- Reset: asynchronous, active-low (resetn=0). All outputs 0; shadow registers, captured mask, stability counter and last-sample registers all 0.
- Accepted sample: sample_en=1 and digit_sel exactly one-hot.
  - sample_en=1 with non-one-hot digit_sel (zero or multi-bit): sample ignored, stability counter cleared to 0.
  - sample_en=0: no change to any state.
- Stability counter, width 8:
  - Accepted sample equal to the stored {digit_sel, seven}: increment, saturating at STABLE_CYCLES.
  - Accepted sample that differs: store it, counter=1.
- Qualification: fires on the clock edge where the counter reaches STABLE_CYCLES. Fires once per run; further identical samples do not re-qualify.
- Decode table (seven → nibble):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7.
  - 0000000→8, 0010000→9, 0001000→A, 0000011→B, 1000110→C, 0100001→D, 0000110→E, 0001110→F.
  - 1111111 = blank: nibble 0, blank bit 1.
  - Any other pattern is invalid.
- On a valid or blank qualification: write shadow nibble and shadow blank bit for that digit; set captured mask bit.
  - Re-qualification of an already-captured digit overwrites its shadow (latest wins).
- On an invalid qualification:
  - pattern_error=1 on the next edge.
  - Captured mask cleared; the frame is abandoned.
  - Shadow registers and outputs unchanged.
- Frame completion, states COLLECT → EMIT → COLLECT:
  - COLLECT: when the captured mask becomes all ones, go to EMIT.
  - EMIT, a single cycle: value and blank_mask load from shadow, frame_valid=1, captured mask cleared, return to COLLECT.
  - frame_valid rises exactly one cycle after the edge on which the last digit qualified.
  - A qualification arriving during the EMIT cycle is applied to the shadow and mask after the mask clear; it counts toward the next frame.
- error_clr clears pattern_error. If error_clr and an invalid qualification occur on the same cycle, set wins.
- value and blank_mask hold between frames. A reset mid-frame discards partial capture; no frame_valid is produced.

Test Plan (NUM_DIGITS=4, STABLE_CYCLES=3):
- Reset: drive resetn=0 asynchronously mid-cycle → value=16'h0000, blank_mask=0, frame_valid=0, pattern_error=0 immediately.
- Normal frame: digits 0..3 present 1111001, 0100100, 0110000, 0011001, each held 3 samples → one frame_valid pulse one cycle after the 12th sample edge; value=16'h4321, blank_mask=4'b0000.
- Glitch rejection: digit 1 held 2 samples of 0100100, then 3 samples of 0000010, plus other digits as in the normal frame → value[7:4]=6.
  - Also: a digit held only 2 samples in total → no frame_valid.
- Invalid pattern: digit 2 holds 1010101 for 3 samples → pattern_error=1 next cycle; no frame_valid; value unchanged. error_clr pulse → pattern_error=0.
- Blank digit: digit 3 = 1111111, others 0,0,0 → value=16'h0000, blank_mask=4'b1000.
- Bad select and reset mid-frame:
  - digit_sel=4'b0011 for 5 cycles → ignored, counter cleared.
  - Capture 3 digits, then assert resetn=0 → next complete frame requires all 4 digits; no stale frame_valid.

Source files
------------

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: samples a multiplexed, active-low seven-segment bus,
// qualifies each digit pattern for stability, decodes it back to a hex nibble
// and assembles complete multi-digit frames.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   COLLECT | gathering qualified digits into the shadow registers
//   EMIT    | one cycle: frame just published, frame_valid high
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    sample_en,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic [6:0]              seven,
  input  logic                    error_clr,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    frame_valid,
  output logic                    pattern_error
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_EMIT    = 1'b1;
  localparam logic [7:0] STABLE_TC  = 8'(STABLE_CYCLES);

  logic [0:0]              state;
  logic [NUM_DIGITS-1:0]   last_sel;
  logic [6:0]              last_seg;
  logic [7:0]              stab_cnt;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [NUM_DIGITS-1:0]   cap_mask;
  logic [NUM_DIGITS-1:0]   mask_base;

  logic       sel_onehot;
  logic       accepted;
  logic       same;
  logic       qualify;
  logic       emit;
  logic [5:0] dec;
  logic       d_ok;
  logic       d_blank;
  logic [3:0] d_nib;

  // Returns {valid, blank, nibble}; blank decodes as valid with nibble 0.
  function automatic logic [5:0] decode(input logic [6:0] s);
    logic [5:0] r;
    r = 6'b00_0000;
    case (s)
      7'b1000000: r = {2'b10, 4'h0};
      7'b1111001: r = {2'b10, 4'h1};
      7'b0100100: r = {2'b10, 4'h2};
      7'b0110000: r = {2'b10, 4'h3};
      7'b0011001: r = {2'b10, 4'h4};
      7'b0010010: r = {2'b10, 4'h5};
      7'b0000010: r = {2'b10, 4'h6};
      7'b1111000: r = {2'b10, 4'h7};
      7'b0000000: r = {2'b10, 4'h8};
      7'b0010000: r = {2'b10, 4'h9};
      7'b0001000: r = {2'b10, 4'hA};
      7'b0000011: r = {2'b10, 4'hB};
      7'b1000110: r = {2'b10, 4'hC};
      7'b0100001: r = {2'b10, 4'hD};
      7'b0000110: r = {2'b10, 4'hE};
      7'b0001110: r = {2'b10, 4'hF};
      7'b1111111: r = {2'b11, 4'h0};
      default:    r = 6'b00_0000;
    endcase
    return r;
  endfunction

  // Sample acceptance, run-length qualification and pattern decode.
  always_comb begin
    sel_onehot = $onehot(digit_sel);
    accepted   = sample_en && sel_onehot;
    same       = (digit_sel == last_sel) && (seven == last_seg);
    qualify    = 1'b0;
    if (accepted) begin
      if (same)
        qualify = (stab_cnt != STABLE_TC) && ((stab_cnt + 8'd1) == STABLE_TC);
      else
        qualify = (STABLE_TC == 8'd1);
    end
    dec       = decode(seven);
    d_ok      = dec[5];
    d_blank   = dec[4];
    d_nib     = dec[3:0];
    emit      = (state == ST_COLLECT) && (&cap_mask);
    // Emission clears the mask first so a same-edge qualification seeds the next frame.
    mask_base = emit ? '0 : cap_mask;
  end

  // Stability counter and last-sample registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_sel <= '0;
      last_seg <= '0;
      stab_cnt <= '0;
    end else if (sample_en) begin
      if (!sel_onehot) begin
        stab_cnt <= '0;
      end else if (same) begin
        if (stab_cnt != STABLE_TC)
          stab_cnt <= stab_cnt + 8'd1;
      end else begin
        last_sel <= digit_sel;
        last_seg <= seven;
        stab_cnt <= 8'd1;
      end
    end
  end

  // Shadow registers and captured-digit mask.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_val   <= '0;
      shadow_blank <= '0;
      cap_mask     <= '0;
    end else if (qualify && d_ok) begin
      cap_mask <= mask_base | digit_sel;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_sel[i]) begin
          shadow_val[4*i +: 4] <= d_nib;
          shadow_blank[i]      <= d_blank;
        end
      end
    end else if (qualify) begin
      cap_mask <= '0;
    end else begin
      cap_mask <= mask_base;
    end
  end

  // Frame FSM and published outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_COLLECT;
      value       <= '0;
      blank_mask  <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (emit) begin
            state       <= ST_EMIT;
            value       <= shadow_val;
            blank_mask  <= shadow_blank;
            frame_valid <= 1'b1;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

  // Sticky error flag; a new invalid qualification wins over a clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      pattern_error <= 1'b0;
    else if (qualify && !d_ok)
      pattern_error <= 1'b1;
    else if (error_clr)
      pattern_error <= 1'b0;
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: directed frames followed by random bus
// traffic, all checked against a digit/run-length reference model.
module tb_seven_segment_capture;

  localparam int ND = 4;
  localparam int SC = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          sample_en;
  logic [ND-1:0] digit_sel;
  logic [6:0]    seven;
  logic          error_clr;
  logic [15:0]   value;
  logic [ND-1:0] blank_mask;
  logic          frame_valid;
  logic          pattern_error;

  seven_segment_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .resetn(resetn), .sample_en(sample_en), .digit_sel(digit_sel),
    .seven(seven), .error_clr(error_clr), .value(value), .blank_mask(blank_mask),
    .frame_valid(frame_valid), .pattern_error(pattern_error)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] BAD   = 7'b1010101;

  // Reference model state
  logic [ND-1:0] m_last_sel;
  logic [6:0]    m_last_seg;
  int            m_run;
  logic [3:0]    m_sh_nib [ND];
  bit            m_sh_blank [ND];
  bit            m_cap [ND];
  bit            m_full;
  logic [15:0]   m_value;
  logic [ND-1:0] m_blank;
  bit            m_fv;
  bit            m_err;
  bit            seen_fv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int decode_ref(input logic [6:0] s);
    for (int k = 0; k < 16; k++)
      if (seg_tab[k] == s) return k;
    if (s == BLANK) return 16;
    return -1;
  endfunction

  task automatic model_reset();
    m_last_sel = '0; m_last_seg = '0; m_run = 0;
    for (int k = 0; k < ND; k++) begin
      m_sh_nib[k] = 4'h0; m_sh_blank[k] = 1'b0; m_cap[k] = 1'b0;
    end
    m_full = 1'b0; m_value = '0; m_blank = '0; m_fv = 1'b0; m_err = 1'b0;
  endtask

  // Advance the model by one clock edge with the given bus inputs.
  task automatic model_edge(input bit en, input logic [ND-1:0] sel,
                            input logic [6:0] seg, input bit clr);
    bit qual;
    int d;
    int code;
    qual = 1'b0;
    d    = 0;
    if (m_full) begin
      for (int k = 0; k < ND; k++) begin
        m_value[4*k +: 4] = m_sh_nib[k];
        m_blank[k]        = m_sh_blank[k];
        m_cap[k]          = 1'b0;
      end
      m_fv = 1'b1;
    end else begin
      m_fv = 1'b0;
    end
    if (clr) m_err = 1'b0;
    if (en) begin
      if ($countones(sel) == 1) begin
        if (sel == m_last_sel && seg == m_last_seg) begin
          if (m_run < SC) begin
            m_run++;
            qual = (m_run == SC);
          end
        end else begin
          m_last_sel = sel; m_last_seg = seg; m_run = 1;
          qual = (SC == 1);
        end
      end else begin
        m_run = 0;
      end
    end
    if (qual) begin
      for (int k = 0; k < ND; k++) if (sel[k]) d = k;
      code = decode_ref(seg);
      if (code < 0) begin
        m_err = 1'b1;
        for (int k = 0; k < ND; k++) m_cap[k] = 1'b0;
      end else begin
        m_sh_nib[d]   = (code == 16) ? 4'h0 : code[3:0];
        m_sh_blank[d] = (code == 16);
        m_cap[d]      = 1'b1;
      end
    end
    m_full = 1'b1;
    for (int k = 0; k < ND; k++) if (!m_cap[k]) m_full = 1'b0;
  endtask

  task automatic check_outputs();
    chk("value", value, m_value);
    chk("blank_mask", blank_mask, m_blank);
    chk("frame_valid", frame_valid, m_fv);
    chk("pattern_error", pattern_error, m_err);
  endtask

  task automatic step(input bit en, input logic [ND-1:0] sel,
                      input logic [6:0] seg, input bit clr);
    @(negedge clk);
    sample_en = en; digit_sel = sel; seven = seg; error_clr = clr;
    @(posedge clk);
    #1;
    model_edge(en, sel, seg, clr);
    check_outputs();
    if (frame_valid) seen_fv = 1'b1;
  endtask

  task automatic hold(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) step(1'b1, sel, seg, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    resetn = 1'b0; sample_en = 1'b0; error_clr = 1'b0;
    #1;
    model_reset();
    chk("rst_value", value, 32'h0);
    chk("rst_blank", blank_mask, 32'h0);
    chk("rst_fv", frame_valid, 32'h0);
    chk("rst_err", pattern_error, 32'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [ND-1:0] rsel;
    logic [6:0]    rseg;
    int            len;
    resetn = 1'b0; sample_en = 1'b0; digit_sel = '0; seven = '0; error_clr = 1'b0;
    seen_fv = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    resetn = 1'b1;

    // Normal frame 4321
    hold(4'b0001, seg_tab[1], 3);
    hold(4'b0010, seg_tab[2], 3);
    hold(4'b0100, seg_tab[3], 3);
    hold(4'b1000, seg_tab[4], 3);
    chk("fv_not_early", frame_valid, 32'h0);
    idle(1);
    chk("fv_normal", frame_valid, 32'h1);
    chk("value_normal", value, 32'h4321);
    chk("blank_normal", blank_mask, 32'h0);
    idle(1);
    chk("fv_one_cycle", frame_valid, 32'h0);

    // Asynchronous reset mid-cycle clears published frame
    do_reset();

    // Glitch rejection on digit 1
    hold(4'b0001, seg_tab[1], 3);
    hold(4'b0010, seg_tab[2], 2);
    hold(4'b0010, seg_tab[6], 3);
    hold(4'b0100, seg_tab[3], 3);
    hold(4'b1000, seg_tab[4], 3);
    idle(1);
    chk("value_glitch", value, 32'h4361);
    idle(1);

    // Digit 3 held only 2 samples: frame never completes
    seen_fv = 1'b0;
    hold(4'b0001, seg_tab[1], 3);
    hold(4'b0010, seg_tab[2], 3);
    hold(4'b0100, seg_tab[3], 3);
    hold(4'b1000, seg_tab[4], 2);
    idle(4);
    chk("short_no_fv", seen_fv, 32'h0);

    // Invalid pattern on digit 2 abandons the frame
    hold(4'b0100, BAD, 3);
    idle(1);
    chk("err_set", pattern_error, 32'h1);
    chk("value_kept", value, 32'h4361);
    hold(4'b1000, BLANK, 3);
    idle(2);
    chk("abandon_no_fv", seen_fv, 32'h0);
    step(1'b0, '0, '0, 1'b1);
    chk("err_clr", pattern_error, 32'h0);

    // Blank digit 3 (already captured above), digits 0..2 show 0
    hold(4'b0001, seg_tab[0], 3);
    hold(4'b0010, seg_tab[0], 3);
    hold(4'b0100, seg_tab[0], 3);
    idle(1);
    chk("fv_blank", frame_valid, 32'h1);
    chk("value_blank", value, 32'h0000);
    chk("blank_bits", blank_mask, 32'h8);

    // Bad select clears the run, then reset mid-frame
    hold(4'b0011, seg_tab[1], 5);
    hold(4'b0001, seg_tab[1], 2);
    hold(4'b0011, seg_tab[1], 1);
    hold(4'b0001, seg_tab[1], 2);
    hold(4'b0001, seg_tab[7], 3);
    hold(4'b0010, seg_tab[8], 3);
    hold(4'b0100, seg_tab[9], 3);
    do_reset();
    seen_fv = 1'b0;
    hold(4'b1000, seg_tab[10], 3);
    idle(3);
    chk("no_stale_fv", seen_fv, 32'h0);
    hold(4'b0001, seg_tab[7], 3);
    hold(4'b0010, seg_tab[8], 3);
    hold(4'b0100, seg_tab[9], 3);
    idle(1);
    chk("fv_after_rst", frame_valid, 32'h1);
    chk("value_after_rst", value, 32'hA987);

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) == 0) rsel = 4'($urandom);
      else rsel = 4'(1 << $urandom_range(0, ND - 1));
      case ($urandom_range(0, 9))
        0:       rseg = BLANK;
        1:       rseg = 7'($urandom);
        default: rseg = seg_tab[$urandom_range(0, 15)];
      endcase
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++)
        step(($urandom_range(0, 9) != 0), rsel, rseg, ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
